// File: rtl/dragon_pkg.sv
// Shared constants, state encodings and helpers for the Dragon serial program loader.
package dragon_pkg;

    localparam int DRAGON_WORD_WIDTH = 36;
    localparam logic [7:0] DRAGON_LOADER_SYNC = 8'hA5;
    localparam int DRAGON_BYTES_PER_WORD = 5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN_LO,
        LDR_LEN_HI,
        LDR_DATA,
        LDR_CHECK,
        LDR_RUN
    } loader_state_e;

    typedef enum logic [1:0] {
        URX_IDLE,
        URX_START,
        URX_DATA,
        URX_STOP
    } uart_state_e;

    function automatic logic len_ok(input logic [15:0] len, input int unsigned max_words);
        return (len != 16'd0) && (32'(len) <= max_words);
    endfunction

endpackage

// File: rtl/dragon_boot_loader_if.sv
// Loader-side signal bundle: serial input plus the program-RAM write port and status.
interface dragon_boot_loader_if #(
    parameter int AddressWidth = 10
);
    import dragon_pkg::*;

    logic                         rx;
    logic                         ram_write_enable;
    logic [AddressWidth-1:0]      ram_address;
    logic [DRAGON_WORD_WIDTH-1:0] ram_write_data;
    logic                         core_run;
    logic                         busy;
    logic                         error;

    modport master (
        input  rx,
        output ram_write_enable, ram_address, ram_write_data, core_run, busy, error
    );

    modport slave (
        output rx,
        input  ram_write_enable, ram_address, ram_write_data, core_run, busy, error
    );

endinterface

// File: rtl/dragon_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling via a down-counter, one-cycle
// byte_valid / frame_error pulses.
module dragon_uart_rx
    import dragon_pkg::*;
#(
    parameter int BaudDivisor = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int CW = $clog2(BaudDivisor);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BaudDivisor / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BaudDivisor - 1);

    uart_state_e   state_q;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // Synchronizer resets to idle-high so release from reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= URX_IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev_q <= rx_s;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            case (state_q)
                URX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= URX_START;
                    end
                end
                URX_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s) begin
                        state_q <= URX_IDLE;
                    end else begin
                        cnt_q     <= FULL_LOAD;
                        bit_cnt_q <= '0;
                        state_q   <= URX_DATA;
                    end
                end
                URX_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= URX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                URX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state_q <= URX_IDLE;
                    end
                end
                default: state_q <= URX_IDLE;
            endcase
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = valid_q;
    assign frame_error_o = ferr_q;

endmodule

// File: rtl/dragon_boot_loader.sv
// Frame FSM, 36-bit word assembly and program-RAM write port for the Dragon loader.
// Optional checksum byte and CHECK state enabled by defining DRAGON_LOADER_CHECKSUM_EN.
//
// state      | meaning
// LDR_IDLE   | waiting for sync byte 0xA5, other bytes ignored
// LDR_LEN_LO | expecting LEN[7:0]
// LDR_LEN_HI | expecting LEN[15:8], then range check
// LDR_DATA   | assembling 5-byte words, one write strobe per word
// LDR_CHECK  | expecting XOR checksum of LEN and data bytes
// LDR_RUN    | load done, core released; terminal until reset
module dragon_boot_loader
    import dragon_pkg::*;
#(
    parameter int AddressWidth = 10,
    parameter int WordCount    = 1024,
    parameter int BaudDivisor  = 434
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    dragon_boot_loader_if.master ldr_io
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    dragon_uart_rx #(
        .BaudDivisor (BaudDivisor)
    ) u_uart_rx (
        .clk_i         (clock_i),
        .rst_n_i       (reset_n_i),
        .rx_i          (ldr_io.rx),
        .byte_o        (rx_byte),
        .byte_valid_o  (rx_valid),
        .frame_error_o (rx_ferr)
    );

    loader_state_e                state_q;
    logic [15:0]                  len_q;
    logic [15:0]                  word_cnt_q;
    logic [2:0]                   byte_idx_q;
    logic [31:0]                  data_lo_q;
    logic                         last_q;
    logic                         ram_we_q;
    logic [AddressWidth-1:0]      ram_address_q;
    logic [DRAGON_WORD_WIDTH-1:0] ram_wdata_q;
    logic                         core_run_q;
    logic                         error_q;
    logic [15:0]                  len_full;

    assign len_full = {rx_byte, len_q[7:0]};

`ifdef DRAGON_LOADER_CHECKSUM_EN
    logic [7:0] cks_q;

    // Sitting in IDLE keeps the running checksum clear for the next frame.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cks_q <= '0;
        end else if (state_q == LDR_IDLE) begin
            cks_q <= '0;
        end else if (rx_valid && (state_q inside {LDR_LEN_LO, LDR_LEN_HI, LDR_DATA})) begin
            cks_q <= cks_q ^ rx_byte;
        end
    end
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= LDR_IDLE;
            len_q         <= '0;
            word_cnt_q    <= '0;
            byte_idx_q    <= '0;
            data_lo_q     <= '0;
            last_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
            core_run_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            if (state_q == LDR_RUN) begin
                state_q <= LDR_RUN;
            end else if (rx_ferr) begin
                error_q    <= 1'b1;
                state_q    <= LDR_IDLE;
                word_cnt_q <= '0;
            end else if (state_q == LDR_DATA && ram_we_q && last_q) begin
`ifdef DRAGON_LOADER_CHECKSUM_EN
                state_q <= LDR_CHECK;
`else
                state_q    <= LDR_RUN;
                core_run_q <= 1'b1;
`endif
            end else if (rx_valid) begin
                case (state_q)
                    LDR_IDLE: begin
                        if (rx_byte == DRAGON_LOADER_SYNC) begin
                            error_q    <= 1'b0;
                            word_cnt_q <= '0;
                            byte_idx_q <= '0;
                            state_q    <= LDR_LEN_LO;
                        end
                    end
                    LDR_LEN_LO: begin
                        len_q[7:0] <= rx_byte;
                        state_q    <= LDR_LEN_HI;
                    end
                    LDR_LEN_HI: begin
                        len_q[15:8] <= rx_byte;
                        if (len_ok(len_full, WordCount)) begin
                            byte_idx_q <= '0;
                            state_q    <= LDR_DATA;
                        end else begin
                            error_q    <= 1'b1;
                            word_cnt_q <= '0;
                            state_q    <= LDR_IDLE;
                        end
                    end
                    LDR_DATA: begin
                        if (byte_idx_q != 3'(DRAGON_BYTES_PER_WORD - 1)) begin
                            data_lo_q[byte_idx_q[1:0]*8 +: 8] <= rx_byte;
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end else if (rx_byte[7:4] != 4'h0) begin
                            error_q    <= 1'b1;
                            word_cnt_q <= '0;
                            state_q    <= LDR_IDLE;
                        end else begin
                            ram_wdata_q   <= {rx_byte[3:0], data_lo_q};
                            ram_address_q <= word_cnt_q[AddressWidth-1:0];
                            ram_we_q      <= 1'b1;
                            word_cnt_q    <= word_cnt_q + 16'd1;
                            last_q        <= (word_cnt_q + 16'd1) == len_q;
                            byte_idx_q    <= '0;
                        end
                    end
`ifdef DRAGON_LOADER_CHECKSUM_EN
                    LDR_CHECK: begin
                        if (rx_byte == cks_q) begin
                            state_q    <= LDR_RUN;
                            core_run_q <= 1'b1;
                        end else begin
                            error_q    <= 1'b1;
                            word_cnt_q <= '0;
                            state_q    <= LDR_IDLE;
                        end
                    end
`endif
                    default: begin
                        word_cnt_q <= '0;
                        state_q    <= LDR_IDLE;
                    end
                endcase
            end
        end
    end

    assign ldr_io.ram_write_enable = ram_we_q;
    assign ldr_io.ram_address      = ram_address_q;
    assign ldr_io.ram_write_data   = ram_wdata_q;
    assign ldr_io.core_run         = core_run_q;
    assign ldr_io.error            = error_q;
    assign ldr_io.busy             = (state_q != LDR_IDLE) && (state_q != LDR_RUN);

endmodule
